// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with MEM/WB forwarding, stall/flush and stall counter
// Inputs:  id_* decoded instruction fields, stall/flush control, mem_fwd_*/wb_fwd_* bypass sources
// Outputs: alu_a/alu_b/alu_opcode to the ALU, ex_rt_value store data, ex_rd_addr/ex_reg_write/ex_valid
//          carried downstream, stall_count saturating stalled-cycle counter
module id_ex_stage #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_rs_data,
    input  logic [DATA_W-1:0] id_rt_data,
    input  logic [REG_AW-1:0] id_rs_addr,
    input  logic [REG_AW-1:0] id_rt_addr,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic [15:0]       id_imm,
    input  logic              id_use_imm,
    input  logic              id_imm_sext,
    input  logic [3:0]        id_alu_op,
    input  logic              id_reg_write,
    input  logic              stall,
    input  logic              flush,
    input  logic              mem_fwd_en,
    input  logic [REG_AW-1:0] mem_fwd_addr,
    input  logic [DATA_W-1:0] mem_fwd_data,
    input  logic              wb_fwd_en,
    input  logic [REG_AW-1:0] wb_fwd_addr,
    input  logic [DATA_W-1:0] wb_fwd_data,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_opcode,
    output logic [DATA_W-1:0] ex_rt_value,
    output logic [REG_AW-1:0] ex_rd_addr,
    output logic              ex_reg_write,
    output logic              ex_valid,
    output logic [CNT_W-1:0]  stall_count
);
    logic              valid_q, valid_d, rw_q, rw_d, use_imm_q, use_imm_d, sext_q, sext_d;
    logic [3:0]        op_q, op_d;
    logic [REG_AW-1:0] rd_q, rd_d, rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d;
    logic [DATA_W-1:0] rs_q, rs_d, rt_q, rt_d, fwd_a, fwd_rt, ext_imm;
    logic [15:0]       imm_q, imm_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // r0 is hardwired zero, so it is never bypassed; MEM is younger than WB and wins
    assign fwd_a  = rs_addr_q == '0 ? '0 :
                    (mem_fwd_en && mem_fwd_addr == rs_addr_q) ? mem_fwd_data :
                    (wb_fwd_en && wb_fwd_addr == rs_addr_q) ? wb_fwd_data : rs_q;
    assign fwd_rt = rt_addr_q == '0 ? '0 :
                    (mem_fwd_en && mem_fwd_addr == rt_addr_q) ? mem_fwd_data :
                    (wb_fwd_en && wb_fwd_addr == rt_addr_q) ? wb_fwd_data : rt_q;
    assign ext_imm = sext_q ? {{(DATA_W-16){imm_q[15]}}, imm_q} : {{(DATA_W-16){1'b0}}, imm_q};

    always_comb begin
        valid_d   = valid_q;
        rw_d      = rw_q;
        use_imm_d = use_imm_q;
        sext_d    = sext_q;
        op_d      = op_q;
        rd_d      = rd_q;
        rs_addr_d = rs_addr_q;
        rt_addr_d = rt_addr_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        imm_d     = imm_q;
        cnt_d     = cnt_q;
        if (flush) begin
            valid_d   = 1'b0;
            rw_d      = 1'b0;
            use_imm_d = 1'b0;
            sext_d    = 1'b0;
            op_d      = '0;
            rd_d      = '0;
            rs_addr_d = '0;
            rt_addr_d = '0;
            rs_d      = '0;
            rt_d      = '0;
            imm_d     = '0;
        end else if (stall) begin
            // Re-capture resolved operands so a producer leaving WB mid-stall is not lost
            rs_d  = fwd_a;
            rt_d  = fwd_rt;
            cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
        end else begin
            valid_d   = id_valid;
            rw_d      = id_reg_write & id_valid;
            use_imm_d = id_use_imm;
            sext_d    = id_imm_sext;
            op_d      = id_alu_op;
            rd_d      = id_rd_addr;
            rs_addr_d = id_rs_addr;
            rt_addr_d = id_rt_addr;
            rs_d      = id_rs_data;
            rt_d      = id_rt_data;
            imm_d     = id_imm;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            rw_q      <= 1'b0;
            use_imm_q <= 1'b0;
            sext_q    <= 1'b0;
            op_q      <= '0;
            rd_q      <= '0;
            rs_addr_q <= '0;
            rt_addr_q <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            imm_q     <= '0;
            cnt_q     <= '0;
        end else begin
            valid_q   <= valid_d;
            rw_q      <= rw_d;
            use_imm_q <= use_imm_d;
            sext_q    <= sext_d;
            op_q      <= op_d;
            rd_q      <= rd_d;
            rs_addr_q <= rs_addr_d;
            rt_addr_q <= rt_addr_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            imm_q     <= imm_d;
            cnt_q     <= cnt_d;
        end
    end

    assign alu_a        = fwd_a;
    assign alu_b        = use_imm_q ? ext_imm : fwd_rt;
    assign alu_opcode   = op_q;
    assign ex_rt_value  = fwd_rt;
    assign ex_rd_addr   = rd_q;
    assign ex_reg_write = rw_q;
    assign ex_valid     = valid_q;
    assign stall_count  = cnt_q;
endmodule
